frv_imem_sram_bridge: RTL and testbench

//  Upstream neighbour of the fetch stage: terminates the instruction-memory
//  req/gnt/recv/ack bus on a single-port synchronous SRAM (1-cycle read).

---
 rtl/frv_imem_sram_bridge_pkg.sv | 32 +++
 rtl/frv_rsp_fifo.sv | 62 ++++++
 rtl/frv_imem_sram_bridge.sv | 105 ++++++++++
 tb/tb_frv_imem_sram_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_imem_sram_bridge_pkg.sv
// Shared constants and types for the instruction-memory SRAM bridge.
// The default memory map is also used by the fetch stage.
package frv_imem_sram_bridge_pkg;

    localparam int XL     = 32;
    localparam int WORD_W = 32;

    localparam logic [XL-1:0] MEM_BASE_DEF  = 32'h8000_0000;
    localparam int            MEM_WORDS_DEF = 4096;
    localparam int            RSP_DEPTH_DEF = 2;

    // Read data returned with an error response and with every write response.
    localparam logic [WORD_W-1:0] ERR_RDATA = '0;

    typedef struct packed {
        logic              err;
        logic [WORD_W-1:0] data;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    function automatic logic addr_bad(input logic [XL-1:0] addr,
                                      input logic [XL-1:0] base,
                                      input int            words);
        logic [XL-1:0] off;
        logic [XL:0]   span;
        off  = addr - base;
        span = (XL+1)'(words) << 2;
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, off} >= span);
    endfunction

endpackage

// File: rtl/frv_rsp_fifo.sv
// In-order response FIFO with a combinational head so a response can be
// presented the cycle after it is pushed.
module frv_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

endmodule

// File: rtl/frv_imem_sram_bridge.sv
// Bridges the instruction-memory req/gnt/recv/ack bus onto a 1-cycle
// synchronous SRAM, queueing responses so the requester may stall ack.
module frv_imem_sram_bridge
    import frv_imem_sram_bridge_pkg::*;
#(
    parameter logic [XL-1:0] MEM_BASE  = MEM_BASE_DEF,
    parameter int            MEM_WORDS = MEM_WORDS_DEF,
    parameter int            RSP_DEPTH = RSP_DEPTH_DEF,
    localparam int           AW        = $clog2(MEM_WORDS)
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              imem_req,
    input  logic              imem_wen,
    input  logic [3:0]        imem_strb,
    input  logic [WORD_W-1:0] imem_wdata,
    input  logic [XL-1:0]     imem_addr,
    output logic              imem_gnt,
    output logic              imem_recv,
    input  logic              imem_ack,
    output logic              imem_error,
    output logic [WORD_W-1:0] imem_rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [3:0]        sram_strb,
    output logic [AW-1:0]     sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          bad;
    logic          accept;
    logic [CW:0]   occ;

    logic          inflight_reg;
    logic          inflight_err_reg;
    logic          inflight_wen_reg;

    logic          fifo_push;
    rsp_t          fifo_push_data;
    logic          fifo_pop;
    rsp_t          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign bad = addr_bad(imem_addr, MEM_BASE, MEM_WORDS);

    // The in-flight slot reserves FIFO space so the push at T+1 never overflows.
    assign occ      = {1'b0, fifo_count} + (CW+1)'(inflight_reg);
    assign imem_gnt = imem_req && !fifo_full && (occ < (CW+1)'(RSP_DEPTH));
    assign accept   = imem_gnt && !g_reset;

    assign sram_cen   = accept && !bad;
    assign sram_wen   = imem_wen;
    assign sram_strb  = imem_strb;
    assign sram_wdata = imem_wdata;
    assign sram_addr  = AW'((imem_addr - MEM_BASE) >> 2);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            inflight_reg     <= 1'b0;
            inflight_err_reg <= 1'b0;
            inflight_wen_reg <= 1'b0;
        end else begin
            inflight_reg     <= accept;
            inflight_err_reg <= accept && bad;
            inflight_wen_reg <= accept && imem_wen;
        end
    end

    // SRAM read data is only meaningful for an error-free read.
    always_comb begin
        fifo_push_data.err  = inflight_err_reg;
        fifo_push_data.data = sram_rdata;
        if (inflight_err_reg || inflight_wen_reg) begin
            fifo_push_data.data = ERR_RDATA;
        end
    end

    assign fifo_push = inflight_reg;
    assign fifo_pop  = imem_recv && imem_ack;

    frv_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk       (g_clk),
        .srst      (g_reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_recv  = !fifo_empty;
    assign imem_error = !fifo_empty && fifo_head.err;
    assign imem_rdata = fifo_empty ? '0 : fifo_head.data;

endmodule

// File: tb/tb_frv_imem_sram_bridge.sv
// Directed bench for frv_imem_sram_bridge with a behavioural 1-cycle SRAM
// and an in-order response scoreboard.
module tb_frv_imem_sram_bridge;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        g_clk;
    logic        g_reset;
    logic        imem_req;
    logic        imem_wen;
    logic [3:0]  imem_strb;
    logic [31:0] imem_wdata;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_recv;
    logic        imem_ack;
    logic        imem_error;
    logic [31:0] imem_rdata;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_strb;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q [$];
    logic [31:0] sram_mem [4096];

    frv_imem_sram_bridge dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_req   (imem_req),
        .imem_wen   (imem_wen),
        .imem_strb  (imem_strb),
        .imem_wdata (imem_wdata),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_recv  (imem_recv),
        .imem_ack   (imem_ack),
        .imem_error (imem_error),
        .imem_rdata (imem_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_strb  (sram_strb),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) begin
        if (sram_cen) begin
            if (sram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_strb[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every consumed response must match the oldest granted request.
    always @(negedge g_clk) begin
        #2;
        if (!g_reset && imem_recv && imem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %h expected none at %0t",
                         {imem_error, imem_rdata}, $time);
            end else begin
                chk("rsp_order", {imem_error, imem_rdata}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic req, input logic [31:0] addr, input logic wen,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic ack, input logic [32:0] exp);
        @(negedge g_clk);
        imem_req   = req;
        imem_addr  = addr;
        imem_wen   = wen;
        imem_strb  = strb;
        imem_wdata = wdata;
        imem_ack   = ack;
        #1;
        if (req && imem_gnt && !g_reset) exp_q.push_back(exp);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, ack, 33'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 33'(exp_q.size()), 33'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        cen;
        logic [11:0] sidx;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    initial begin
        vec_t vecs [10];
        int   exp_g [4];
        int   recv_cyc [3];
        int   issued;
        int   nrecv;
        logic r;

        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        int          exp_g [4];
        int          want_cyc [3];
        int          recv_cyc [3];
        logic [31:0] b2b_data [3];
        int          issued;
        int          nrecv;
        logic        r;

        for (int i = 0; i < 4096; i++) sram_mem[i] = 32'h0;
        sram_mem[0]    = 32'h1111_1111;
        sram_mem[1]    = 32'hDEAD_BEEF;
        sram_mem[2]    = 32'h3333_3333;
        sram_mem[4095] = 32'hCAFE_F00D;

        vecs[0] = '{32'h8000_0004, 1'b0, 4'h0, 32'h0,         1'b1, 12'd1,    1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h8000_0000, 1'b0, 4'h0, 32'h0,         1'b1, 12'd0,    1'b0, 32'h1111_1111};
        vecs[2] = '{32'h8000_3FFC, 1'b0, 4'h0, 32'h0,         1'b1, 12'd4095, 1'b0, 32'hCAFE_F00D};
        vecs[3] = '{32'h8000_4000, 1'b0, 4'h0, 32'h0,         1'b0, 12'd0,    1'b1, 32'h0};
        vecs[4] = '{32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0,         1'b0, 12'd0,    1'b1, 32'h0};
        vecs[5] = '{32'h8000_0002, 1'b0, 4'h0, 32'h0,         1'b0, 12'd0,    1'b1, 32'h0};
        vecs[6] = '{32'h8000_0008, 1'b1, 4'h3, 32'hAAAA_5555, 1'b1, 12'd2,    1'b0, 32'h0};
        vecs[7] = '{32'h8000_0008, 1'b0, 4'h0, 32'h0,         1'b1, 12'd2,    1'b0, 32'h3333_5555};
        vecs[8] = '{32'h9000_0000, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 12'd0,    1'b1, 32'h0};
        vecs[9] = '{32'h8000_0001, 1'b0, 4'h0, 32'h0,         1'b0, 12'd0,    1'b1, 32'h0};

        // Reset with a pending request: grant is combinational, SRAM stays idle.
        g_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, BASE + 32'd4, 1'b0, 4'h0, 32'h0, 1'b1, 33'h0);
            chk("rst_gnt", 33'(imem_gnt), 33'd1);
            chk("rst_cen", 33'(sram_cen), 33'd0);
            chk("rst_recv", 33'(imem_recv), 33'd0);
            chk("rst_rsp", {imem_error, imem_rdata}, 33'h0);
        end
        @(negedge g_clk);
        g_reset  = 1'b0;
        imem_req = 1'b0;
        #1;
        chk("post_rst_recv0", 33'(imem_recv), 33'd0);
        idle(1'b1);
        chk("post_rst_recv1", 33'(imem_recv), 33'd0);

        // Single transactions: recv exactly two cycles after the grant.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].addr, vecs[i].wen, vecs[i].strb, vecs[i].wdata, 1'b1,
                 {vecs[i].err, vecs[i].rdata});
            $display("vec%0d addr=%h wen=%0d gnt=%0d cen=%0d", i, vecs[i].addr,
                     vecs[i].wen, imem_gnt, sram_cen);
            chk($sformatf("vec%0d_gnt", i), 33'(imem_gnt), 33'd1);
            chk($sformatf("vec%0d_cen", i), 33'(sram_cen), 33'(vecs[i].cen));
            if (vecs[i].cen) begin
                chk($sformatf("vec%0d_sidx", i), 33'(sram_addr), 33'(vecs[i].sidx));
                chk($sformatf("vec%0d_swen", i), 33'(sram_wen), 33'(vecs[i].wen));
            end
            idle(1'b1);
            chk($sformatf("vec%0d_recv_t1", i), 33'(imem_recv), 33'd0);
            idle(1'b1);
            chk($sformatf("vec%0d_recv_t2", i), 33'(imem_recv), 33'd1);
            chk($sformatf("vec%0d_rsp", i), {imem_error, imem_rdata},
                {vecs[i].err, vecs[i].rdata});
        end

        // Back-to-back reads with ack held high.
        exp_g       = '{1, 1, 0, 1};
        want_cyc    = '{2, 3, 5};
        b2b_data[0] = 32'h1111_1111;
        b2b_data[1] = 32'hDEAD_BEEF;
        b2b_data[2] = 32'h3333_5555;
        issued = 0;
        nrecv  = 0;
        for (int c = 0; c < 10; c++) begin
            r = (issued < 3);
            step(r, BASE + 32'(4 * issued), 1'b0, 4'h0, 32'h0, 1'b1,
                 {1'b0, r ? b2b_data[issued] : 32'h0});
            $display("b2b cyc%0d req=%0d gnt=%0d recv=%0d rdata=%h", c, r, imem_gnt,
                     imem_recv, imem_rdata);
            if (c < 4) chk($sformatf("b2b_gnt%0d", c), 33'(imem_gnt), 33'(exp_g[c]));
            if (r && imem_gnt) issued++;
            if (imem_recv && nrecv < 3) begin
                recv_cyc[nrecv] = c;
                nrecv++;
            end
        end
        chk("b2b_issued", 33'(issued), 33'd3);
        chk("b2b_nrecv", 33'(nrecv), 33'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("b2b_recv_cyc%0d", k),
                                        33'(recv_cyc[k]), 33'(want_cyc[k]));
        chk("b2b_drained", 33'(exp_q.size()), 33'd0);

        // Stalled ack: grants stop at two, head holds, release drains in order.
        step(1'b1, BASE + 32'd4, 1'b0, 4'h0, 32'h0, 1'b0, {1'b0, 32'hDEAD_BEEF});
        chk("stall_gnt0", 33'(imem_gnt), 33'd1);
        step(1'b1, BASE + 32'd0, 1'b0, 4'h0, 32'h0, 1'b0, {1'b0, 32'h1111_1111});
        chk("stall_gnt1", 33'(imem_gnt), 33'd1);
        for (int c = 2; c < 5; c++) begin
            step(1'b1, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b0, {1'b0, 32'h3333_5555});
            $display("stall cyc%0d gnt=%0d recv=%0d rdata=%h", c, imem_gnt, imem_recv, imem_rdata);
            chk($sformatf("stall_gnt%0d", c), 33'(imem_gnt), 33'd0);
            chk($sformatf("stall_head%0d", c), {imem_recv, imem_rdata}, {1'b1, 32'hDEAD_BEEF});
        end
        step(1'b1, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b1, {1'b0, 32'h3333_5555});
        step(1'b1, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b1, {1'b0, 32'h3333_5555});
        chk("stall_regrant", 33'(imem_gnt), 33'd1);
        drain();

        // Reset with two queued responses: both are dropped.
        step(1'b1, BASE + 32'd4, 1'b0, 4'h0, 32'h0, 1'b0, {1'b0, 32'hDEAD_BEEF});
        step(1'b1, BASE + 32'd0, 1'b0, 4'h0, 32'h0, 1'b0, {1'b0, 32'h1111_1111});
        idle(1'b0);
        idle(1'b0);
        chk("rst2_queued", 33'(imem_recv), 33'd1);
        @(negedge g_clk);
        g_reset = 1'b1;
        #1;
        exp_q.delete();
        idle(1'b0);
        chk("rst2_recv", 33'(imem_recv), 33'd0);
        chk("rst2_rsp", {imem_error, imem_rdata}, 33'h0);
        g_reset = 1'b0;
        step(1'b1, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b1, {1'b0, 32'h3333_5555});
        chk("rst2_gnt", 33'(imem_gnt), 33'd1);
        chk("rst2_cen", 33'(sram_cen), 33'd1);
        drain();
        for (int c = 0; c < 3; c++) begin
            idle(1'b1);
            chk($sformatf("rst2_quiet%0d", c), 33'(imem_recv), 33'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
